// File: rtl/ring_buffer_txn_pkg.sv
// Shared types and helpers for the transactional ring buffer.
package RingBufferPkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TXN  = 2'd1,
        BAD  = 2'd2
    } TRingState;

    // Distance from rd to wr, modulo 2**ptr_w.
    function automatic logic [31:0] ringUsed(input logic [31:0] wr,
                                             input logic [31:0] rd,
                                             input int unsigned ptr_w);
        logic [31:0] mask;
        mask = (32'd1 << ptr_w) - 32'd1;
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/ring_buffer_txn_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port (latency 1).
module ring_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Output register holds the last word read until the next accepted read.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/ring_buffer_txn.sv
// Ring buffer whose writes are staged by an open/commit/rollback transaction;
// the reader only ever sees committed words.
module ring_buffer_txn
    import RingBufferPkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_request,
    output logic                  push_done,
    input  logic                  pop_request,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_done,
    input  logic                  open,
    input  logic                  commit,
    input  logic                  rollback,
    output logic [ADDR_WIDTH:0]   mem_used,
    output logic                  txn_error
);

    localparam int PTR_W = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    TRingState        state;
    logic [PTR_W-1:0] rptr, wcommit, wtent;
    logic [PTR_W-1:0] tent_used, wtent_inc, wcommit_n, rptr_n;
    logic             full, push_live, push_ok, overflow, pop_ok;
    logic             commit_ok, commit_bad;

    assign tent_used = PTR_W'(ringUsed(32'(wtent), 32'(rptr), PTR_W));
    assign full      = (tent_used == PTR_W'(DEPTH));

    // A push counts only in TXN and when neither rollback nor a winning open
    // discards it; a coinciding commit takes the word along.
    assign push_live = push_request && (state == TXN) && !rollback && (commit || !open);
    assign push_ok   = push_live && !full;
    assign overflow  = push_live && full;
    assign pop_ok    = pop_request && (mem_used != '0);

    assign commit_ok  = commit && !rollback && (state == TXN) && !overflow;
    assign commit_bad = commit && !rollback && ((state == BAD) || ((state == TXN) && overflow));

    assign wtent_inc = wtent + PTR_W'(push_ok);
    assign wcommit_n = commit_ok ? wtent_inc : wcommit;
    assign rptr_n    = rptr + PTR_W'(pop_ok);

    ring_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push_ok),
        .wr_addr(wtent[ADDR_WIDTH-1:0]),
        .wr_data(push_data),
        .rd_en  (pop_ok),
        .rd_addr(rptr[ADDR_WIDTH-1:0]),
        .rd_data(pop_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rptr      <= '0;
            wcommit   <= '0;
            wtent     <= '0;
            mem_used  <= '0;
            push_done <= 1'b0;
            pop_done  <= 1'b0;
            txn_error <= 1'b0;
        end else begin
            push_done <= push_ok;
            pop_done  <= pop_ok;
            txn_error <= commit_bad;
            rptr      <= rptr_n;
            wcommit   <= wcommit_n;
            mem_used  <= PTR_W'(ringUsed(32'(wcommit_n), 32'(rptr_n), PTR_W));
            if (rollback) begin
                wtent <= wcommit;
                state <= IDLE;
            end else if (commit) begin
                wtent <= wcommit_n;
                state <= IDLE;
            end else if (open) begin
                wtent <= wcommit;
                state <= TXN;
            end else begin
                wtent <= wtent_inc;
                if (overflow)
                    state <= BAD;
            end
        end
    end

endmodule
